// File: rtl/fruit_spawner.sv
// Multi-fruit placer for the snake board: LFSR candidate, occupancy check, commit of cell-centre pixels.
// Optional macro FRUIT_SPAWNER_SCORE_EN adds a saturating eaten_count output.
module fruit_spawner #(
  parameter int          NUM_FRUITS = 4,
  parameter int          GRID_X     = 80,
  parameter int          GRID_Y     = 60,
  parameter int          CELL_PX    = 10,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          MAX_TRIES  = 15,
  parameter logic [7:0]  FRUIT_RGB  = 8'b111_000_00
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_FRUITS-1:0]     comer,
  input  logic [6:0]                head_cell_x,
  input  logic [6:0]                head_cell_y,
  output logic [12*NUM_FRUITS-1:0]  fruit_x,
  output logic [12*NUM_FRUITS-1:0]  fruit_y,
  output logic [NUM_FRUITS-1:0]     fruit_valid,
  output logic [7:0]                fruit_rgb,
  output logic                      busy
`ifdef FRUIT_SPAWNER_SCORE_EN
  ,
  output logic [15:0]               eaten_count
`endif
);
  localparam int          IW      = (NUM_FRUITS > 1) ? $clog2(NUM_FRUITS) : 1;
  localparam int          TW      = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;
  localparam logic [TW-1:0] TRY_MAX = TW'(MAX_TRIES);
  localparam logic [7:0]  GX8     = 8'(GRID_X);
  localparam logic [7:0]  GY8     = 8'(GRID_Y);
  localparam logic [6:0]  RST_CX  = 7'(GRID_X / 2 - 1);
  localparam logic [6:0]  RST_CY  = 7'(GRID_Y / 2 - 1);
  localparam logic [11:0] PX_MUL  = 12'(CELL_PX);
  localparam logic [11:0] PX_OFF  = 12'(CELL_PX / 2);

  typedef enum logic [1:0] {S_IDLE, S_PICK, S_CHECK, S_COMMIT} state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d, low_idx;
  logic [TW-1:0]           tries_q, tries_d;
  logic [6:0]              cx_q, cx_d, cy_q, cy_d, cand_x, cand_y;
  logic [15:0]             lfsr_q;
  logic [NUM_FRUITS-1:0]   comer_q, rise, accept;
  logic [NUM_FRUITS-1:0]   valid_q, valid_d, pending_q, pending_d;
  logic [6:0]              cellx_q [NUM_FRUITS];
  logic [6:0]              cellx_d [NUM_FRUITS];
  logic [6:0]              celly_q [NUM_FRUITS];
  logic [6:0]              celly_d [NUM_FRUITS];
  logic [7:0]              rgb_q;
  logic                    conflict, in_range;

  assign rise     = comer & ~comer_q;
  assign accept   = rise & valid_q;
  assign cand_x   = lfsr_q[6:0];
  assign cand_y   = lfsr_q[14:8];
  assign in_range = ({1'b0, cand_x} < GX8) && ({1'b0, cand_y} < GY8);

  always_comb begin
    low_idx = '0;
    for (int i = NUM_FRUITS - 1; i >= 0; i--)
      if (pending_q[i]) low_idx = IW'(i);
  end

  // The fruit being placed is invalid, so only other live fruits and the head can block a cell.
  always_comb begin
    conflict = (cx_q == head_cell_x) && (cy_q == head_cell_y);
    for (int j = 0; j < NUM_FRUITS; j++)
      if ((IW'(j) != idx_q) && valid_q[j] && (cellx_q[j] == cx_q) && (celly_q[j] == cy_q))
        conflict = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tries_d   = tries_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    valid_d   = valid_q & ~accept;
    pending_d = pending_q | accept;
    cellx_d   = cellx_q;
    celly_d   = celly_q;
    case (state_q)
      S_IDLE: begin
        if (pending_q != '0) begin
          idx_d   = low_idx;
          tries_d = '0;
          state_d = S_PICK;
        end
      end
      S_PICK: begin
        if (in_range) begin
          cx_d    = cand_x;
          cy_d    = cand_y;
          state_d = S_CHECK;
        end else if (tries_q == TRY_MAX) begin
          cx_d    = 7'({1'b0, cand_x} % GX8);
          cy_d    = 7'({1'b0, cand_y} % GY8);
          state_d = S_CHECK;
        end else begin
          tries_d = tries_q + TW'(1);
        end
      end
      S_CHECK: begin
        if (conflict && (tries_q < TRY_MAX)) begin
          tries_d = tries_q + TW'(1);
          state_d = S_PICK;
        end else begin
          state_d = S_COMMIT;
        end
      end
      default: begin
        for (int i = 0; i < NUM_FRUITS; i++) begin
          if (IW'(i) == idx_q) begin
            cellx_d[i]   = cx_q;
            celly_d[i]   = cy_q;
            valid_d[i]   = 1'b1;
            pending_d[i] = 1'b0;
          end
        end
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tries_q   <= '0;
      lfsr_q    <= LFSR_SEED;
      comer_q   <= '0;
      valid_q   <= '0;
      pending_q <= '1;
      rgb_q     <= FRUIT_RGB;
      for (int i = 0; i < NUM_FRUITS; i++) begin
        cellx_q[i] <= RST_CX;
        celly_q[i] <= RST_CY;
      end
    end else begin
      state_q   <= state_d;
      tries_q   <= tries_d;
      lfsr_q    <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      comer_q   <= comer;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      rgb_q     <= FRUIT_RGB;
      cellx_q   <= cellx_d;
      celly_q   <= celly_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_q <= idx_d;
    cx_q  <= cx_d;
    cy_q  <= cy_d;
  end

  always_comb begin
    for (int i = 0; i < NUM_FRUITS; i++) begin
      fruit_x[12*i +: 12] = 12'(cellx_q[i]) * PX_MUL + PX_OFF;
      fruit_y[12*i +: 12] = 12'(celly_q[i]) * PX_MUL + PX_OFF;
    end
  end

  assign fruit_valid = valid_q;
  assign fruit_rgb   = rgb_q;
  assign busy        = (state_q != S_IDLE);

`ifdef FRUIT_SPAWNER_SCORE_EN
  logic [15:0] score_q;
  logic [16:0] score_sum;

  always_comb begin
    score_sum = {1'b0, score_q};
    for (int i = 0; i < NUM_FRUITS; i++) score_sum = score_sum + 17'(accept[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) score_q <= '0;
    else     score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  assign eaten_count = score_q;
`endif
endmodule

// File: tb/tb_fruit_spawner.sv
// Scoreboard bench for fruit_spawner: a default 80x60 board and a 2x1 board that forces the accept path.
`timescale 1ns/1ps
module tb_fruit_spawner;
  localparam int NF   = 4;
  localparam int MAXT = 15;
  localparam int HX   = 40;
  localparam int HY   = 30;
  localparam int LT_N = 4096;

  typedef struct {int idx; int x; int y; int k;} exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NF-1:0]   comer;
  logic [6:0]      hx, hy;
  logic [12*NF-1:0] fx, fy;
  logic [NF-1:0]   fv;
  logic [7:0]      rgb;
  logic            busy;
  logic [1:0]      comer2;
  logic [6:0]      hx2, hy2;
  logic [23:0]     fx2, fy2;
  logic [1:0]      fv2;
  logic [7:0]      rgb2;
  logic            busy2;
`ifdef FRUIT_SPAWNER_SCORE_EN
  logic [15:0]     cnt, cnt2;
`endif

  fruit_spawner u_dut (
    .clk(clk), .rst(rst), .comer(comer), .head_cell_x(hx), .head_cell_y(hy),
    .fruit_x(fx), .fruit_y(fy), .fruit_valid(fv), .fruit_rgb(rgb), .busy(busy)
`ifdef FRUIT_SPAWNER_SCORE_EN
    , .eaten_count(cnt)
`endif
  );

  fruit_spawner #(.NUM_FRUITS(2), .GRID_X(2), .GRID_Y(1)) u_small (
    .clk(clk), .rst(rst), .comer(comer2), .head_cell_x(hx2), .head_cell_y(hy2),
    .fruit_x(fx2), .fruit_y(fy2), .fruit_valid(fv2), .fruit_rgb(rgb2), .busy(busy2)
`ifdef FRUIT_SPAWNER_SCORE_EN
    , .eaten_count(cnt2)
`endif
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc;
  int   lt [LT_N];
  exp_t q1[$];
  exp_t q2[$];
  logic [7:0]  mv1, mv2;
  logic [55:0] mcx1, mcy1, mcx2, mcy2;
  int   mfree1, mfree2;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Walks the LFSR table from the cycle the FSM leaves IDLE until a cell is committed.
  function automatic void model_place(input int gx, input int gy, input int kidle, input int idx,
                                      input int nf, input int phx, input int phy, input logic [7:0] vm,
                                      input logic [55:0] mx, input logic [55:0] my,
                                      output int ox, output int oy, output int kv);
    int k, tries, cx, cy;
    bit done, conf, inr;
    k = kidle + 1; tries = 0; done = 0; ox = 0; oy = 0; kv = 0;
    while (!done && k < LT_N - 2) begin
      cx  = lt[k] & 127;
      cy  = (lt[k] >> 8) & 127;
      inr = (cx < gx) && (cy < gy);
      if (!inr && tries < MAXT) begin
        tries++; k++;
      end else begin
        if (!inr) begin cx = cx % gx; cy = cy % gy; end
        k++;
        conf = (cx == phx) && (cy == phy);
        for (int j = 0; j < nf; j++)
          if (j != idx && vm[j] && int'(mx[7*j +: 7]) == cx && int'(my[7*j +: 7]) == cy) conf = 1;
        if (conf && tries < MAXT) begin
          tries++; k++;
        end else begin
          ox = cx; oy = cy; kv = k + 2; done = 1;
        end
      end
    end
  endfunction

  task automatic sched1(input logic [7:0] mask, input int kpend);
    int ox, oy, kv, kidle;
    exp_t e;
    for (int i = 0; i < NF; i++) begin
      if (mask[i]) begin
        kidle = (kpend > mfree1) ? kpend : mfree1;
        model_place(80, 60, kidle, i, NF, HX, HY, mv1, mcx1, mcy1, ox, oy, kv);
        mv1[i] = 1'b1; mcx1[7*i +: 7] = 7'(ox); mcy1[7*i +: 7] = 7'(oy); mfree1 = kv;
        e.idx = i; e.x = ox * 10 + 5; e.y = oy * 10 + 5; e.k = kv;
        q1.push_back(e);
      end
    end
  endtask

  task automatic sched2(input logic [7:0] mask, input int kpend);
    int ox, oy, kv, kidle;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (mask[i]) begin
        kidle = (kpend > mfree2) ? kpend : mfree2;
        model_place(2, 1, kidle, i, 2, 0, 0, mv2, mcx2, mcy2, ox, oy, kv);
        mv2[i] = 1'b1; mcx2[7*i +: 7] = 7'(ox); mcy2[7*i +: 7] = 7'(oy); mfree2 = kv;
        e.idx = i; e.x = ox * 10 + 5; e.y = oy * 10 + 5; e.k = kv;
        q2.push_back(e);
      end
    end
  endtask

  // Monitors: every fruit_valid rising edge is a commit and must match the next expected entry.
  logic [NF-1:0] pv1 = '0;
  logic [1:0]    pv2 = '0;
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NF; i++) begin
      if (fv[i] && !pv1[i]) begin
        if (q1.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL commit_unexpected: fruit %0d committed at cycle %0d, expected none", i, cyc);
        end else begin
          e = q1.pop_front();
          chk("commit_idx", i, e.idx);
          chk("commit_x", int'(fx[12*i +: 12]), e.x);
          chk("commit_y", int'(fy[12*i +: 12]), e.y);
          chk("commit_cycle", cyc, e.k);
        end
      end
    end
    pv1 <= fv;
  end

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (fv2[i] && !pv2[i]) begin
        if (q2.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL small_commit_unexpected: fruit %0d at cycle %0d, expected none", i, cyc);
        end else begin
          e = q2.pop_front();
          chk("small_idx", i, e.idx);
          chk("small_x", int'(fx2[12*i +: 12]), e.x);
          chk("small_y", int'(fy2[12*i +: 12]), e.y);
          chk("small_cycle", cyc, e.k);
        end
      end
    end
    pv2 <= fv2;
  end

  task automatic wait_drain(input int lim);
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < lim) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    chk("drain_pending", q1.size() + q2.size(), 0);
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc != target && n < 1000) begin
      @(negedge clk); n++;
    end
    if (cyc != target) begin
      n_vec++; n_err++;
      $display("FAIL wait_cycle: at %0d, expected %0d", cyc, target);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_valid", int'(fv), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_small_valid", int'(fv2), 0);
    for (int i = 0; i < NF; i++) begin
      chk("rst_fruit_x", int'(fx[12*i +: 12]), 395);
      chk("rst_fruit_y", int'(fy[12*i +: 12]), 295);
    end
  endtask

  task automatic release_and_respawn();
    mv1 = '0; mv2 = '0; mcx1 = '0; mcy1 = '0; mcx2 = '0; mcy2 = '0;
    mfree1 = 0; mfree2 = 0;
    sched1(8'h0F, 0);
    sched2(8'h03, 0);
    rst = 1'b0;
    wait_drain(600);
    chk("respawn_valid", int'(fv), 15);
    chk("respawn_small_valid", int'(fv2), 3);
  endtask

  initial begin
    int k, ka, kb, n, i2;
    logic [6:0] tmp;
`ifdef FRUIT_SPAWNER_SCORE_EN
    int c0;
`endif
    lt[0] = 32'hACE1;
    for (int i = 1; i < LT_N; i++)
      lt[i] = ((lt[i-1] << 1) & 16'hFFFF) |
              (((lt[i-1] >> 15) ^ (lt[i-1] >> 13) ^ (lt[i-1] >> 12) ^ (lt[i-1] >> 10)) & 1);
    rst = 1'b1; comer = '0; comer2 = '0;
    tmp = 7'(HX); hx = tmp; tmp = 7'(HY); hy = tmp; hx2 = '0; hy2 = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    chk("rst_rgb", int'(rgb), 224);
`ifdef FRUIT_SPAWNER_SCORE_EN
    chk("rst_score", int'(cnt), 0);
`endif

    // Initial respawn on both boards.
    release_and_respawn();
    for (int i = 0; i < NF; i++) begin
      chk("range_x", int'(fx[12*i +: 12] < 12'd800), 1);
      chk("range_y", int'(fy[12*i +: 12] < 12'd600), 1);
      for (int j = i + 1; j < NF; j++)
        chk("distinct_cells", int'(fx[12*i +: 12] != fx[12*j +: 12] || fy[12*i +: 12] != fy[12*j +: 12]), 1);
    end
    for (int i = 0; i < 2; i++) begin
      chk("small_in_range_x", int'(fx2[12*i +: 12] == 12'd5 || fx2[12*i +: 12] == 12'd15), 1);
      chk("small_row0_y", int'(fy2[12*i +: 12]), 5);
    end

    // Single pulse on fruit 2.
    k = cyc; comer[2] = 1'b1; mv1[2] = 1'b0; sched1(8'h04, k + 1);
`ifdef FRUIT_SPAWNER_SCORE_EN
    c0 = int'(cnt);
`endif
    @(negedge clk); comer = '0;
    chk("eat2_valid_cleared", int'(fv[2]), 0);
    wait_drain(200);
    for (int j = 0; j < NF; j++)
      if (j != 2)
        chk("eat2_distinct", int'(fx[24 +: 12] != fx[12*j +: 12] || fy[24 +: 12] != fy[12*j +: 12]), 1);
    chk("eat2_not_head", int'(fx[24 +: 12] != 12'(HX * 10 + 5) || fy[24 +: 12] != 12'(HY * 10 + 5)), 1);
`ifdef FRUIT_SPAWNER_SCORE_EN
    chk("score_single", int'(cnt) - c0, 1);
`endif

    // comer[1] held high for 50 cycles: one event only.
    k = cyc; comer[1] = 1'b1; mv1[1] = 1'b0; sched1(8'h02, k + 1);
    repeat (50) @(negedge clk);
    comer = '0;
    wait_drain(100);
    chk("hold_valid", int'(fv), 15);

    // Second pulse while fruit 1 is still pending is ignored.
    k = cyc; comer[1] = 1'b1; mv1[1] = 1'b0; sched1(8'h02, k + 1);
    @(negedge clk); comer = '0;
    @(negedge clk); comer[1] = 1'b1;
    chk("repulse_still_pending", int'(fv[1]), 0);
    @(negedge clk); comer = '0;
    wait_drain(200);
    repeat (10) @(negedge clk);
    chk("repulse_valid", int'(fv), 15);

    // Simultaneous eats on fruits 1 and 3.
`ifdef FRUIT_SPAWNER_SCORE_EN
    c0 = int'(cnt);
`endif
    k = cyc; comer = 4'b1010; mv1[1] = 1'b0; mv1[3] = 1'b0; sched1(8'h0A, k + 1);
    ka = q1[0].k; kb = q1[1].k;
    @(negedge clk); comer = '0;
    chk("dual_cleared", int'(fv), 5);
    n = 0;
    while (cyc < kb && n < 300) begin
      if (cyc == ka - 1) chk("dual_busy_commit1", int'(busy), 1);
      if (cyc == kb - 1) chk("dual_busy_commit3", int'(busy), 1);
      if (cyc == k + 3)  chk("dual_busy_first", int'(busy), 1);
      @(negedge clk); n++;
    end
    wait_drain(100);
    chk("dual_idle", int'(busy), 0);
    chk("dual_valid", int'(fv), 15);
`ifdef FRUIT_SPAWNER_SCORE_EN
    chk("score_dual", int'(cnt) - c0, 2);
`endif

    // Reset while fruit 0 is in CHECK.
    k = cyc; comer[0] = 1'b1; mv1[0] = 1'b0; sched1(8'h01, k + 1);
    i2 = q1[0].k - 2;
    @(negedge clk); comer = '0;
    wait_cyc(i2);
    rst = 1'b1;
    q1.delete(); q2.delete();
    @(negedge clk);
    check_reset_outputs();
`ifdef FRUIT_SPAWNER_SCORE_EN
    chk("score_after_reset", int'(cnt), 0);
`endif
    release_and_respawn();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fruit_spawner.md
Name: fruit_spawner

Overview:
- Parametrised successor of the single-fruit placer for the snake game.
- Manages NUM_FRUITS independent fruits on a GRID_X x GRID_Y cell board drawn at CELL_PX pixels per cell. Default board is 80x60 cells of 10 px, which gives an 800x600 frame.
- On an eat event it chooses a new cell from a free-running LFSR, rejects cells occupied by the snake head or another live fruit, and publishes the cell-centre pixel coordinates and colour to the VGA renderer.

Parameters:
- NUM_FRUITS, 4, number of fruit channels (1..8).
- GRID_X, 80, board width in cells (at most 128).
- GRID_Y, 60, board height in cells (at most 128).
- CELL_PX, 10, pixels per cell side (even).
- LFSR_SEED, 16'hACE1, LFSR reset value (non-zero).
- MAX_TRIES, 15, rejected candidates allowed before a forced accept.
- FRUIT_RGB, 8'b111_000_00, fruit colour in RRRGGGBB format.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- comer  in  NUM_FRUITS  eat strobe per fruit; a rising edge means the fruit was eaten.
- head_cell_x  in  7  snake head column.
- head_cell_y  in  7  snake head row.
- fruit_x  out  12*NUM_FRUITS  centre pixel X per fruit; fruit i occupies bits [12i+11:12i].
- fruit_y  out  12*NUM_FRUITS  centre pixel Y per fruit, packed the same way.
- fruit_valid  out  NUM_FRUITS  fruit is live and should be drawn.
- fruit_rgb  out  8  FRUIT_RGB, registered.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (rst high at a clk edge):
  - fruit_valid = 0.
  - pending = all ones.
  - Every fruit_x = (GRID_X/2-1)*CELL_PX + CELL_PX/2, which is 395 by default.
  - Every fruit_y = (GRID_Y/2-1)*CELL_PX + CELL_PX/2, which is 295 by default.
  - lfsr = LFSR_SEED; FSM = IDLE; tries = 0; comer edge-detect registers = 0.
  - Reset mid-placement abandons the placement; after release, all fruits are respawned.
- Pixel mapping: pixel = cell*CELL_PX + CELL_PX/2, computed in 12 bits.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle except during reset and never locks at 0.
- Eat detect: comer_d <= comer each cycle. rise[i] = comer[i] & ~comer_d[i].
  - rise[i] while fruit_valid[i] = 1: clears fruit_valid[i] and sets pending[i], both visible the next cycle.
  - rise[i] while fruit_valid[i] = 0: ignored.
  - A held-high comer generates exactly one event.
- FSM:
  - IDLE: if pending != 0, latch idx = lowest set pending bit, tries = 0, go to PICK.
  - PICK: cx = lfsr[6:0], cy = lfsr[14:8].
    - If cx < GRID_X and cy < GRID_Y: register (cx, cy), go to CHECK.
    - Otherwise tries++ and stay in PICK.
  - CHECK: conflict if (cx, cy) equals the head cell, or equals the cell of any j != idx with fruit_valid[j] = 1.
    - Conflict and tries < MAX_TRIES: tries++, go to PICK.
    - Otherwise (no conflict, or tries = MAX_TRIES with forced accept): go to COMMIT.
    - An out-of-range PICK sample with tries = MAX_TRIES also registers (cx mod GRID_X, cy mod GRID_Y) and goes to CHECK. The result is always in range.
  - COMMIT: write fruit_x[idx] and fruit_y[idx]; fruit_valid[idx] = 1; pending[idx] = 0; go to IDLE.
- Best-case latency: the eat edge is sampled at cycle t and fruit_valid returns high at t+4 (pending at t+1, IDLE to PICK at t+1, CHECK at t+2, COMMIT at t+3).
- Simultaneous eats are queued in pending and serviced lowest index first, one placement at a time.
- A fruit being placed is never visible. Other fruits keep their outputs unchanged.
- The head cell is sampled in CHECK only. Head moves after CHECK are not re-checked.

Optional Feature:
- Macro FRUIT_SPAWNER_SCORE_EN.
- Defined:
  - Adds output eaten_count (16 bits), reset to 0.
  - It increments by 1 for each accepted eat event (rise on a valid fruit), saturating at 16'hFFFF.
  - It increments by k for k simultaneous accepted eats in one cycle.
- Undefined: no port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset with defaults: all fruit_x = 395, fruit_y = 295, valid = 0000 during reset. After release, the four fruits commit in order 0..3 at distinct in-range cells, each matching the LFSR reference model, and valid ends at 1111.
- Pulse comer[2] for 1 cycle at t: valid[2] = 0 at t+1. New position matches the model, is not equal to any other fruit or the head, and valid[2] = 1 at t+4 at the earliest.
- Hold comer[1] high for 50 cycles: exactly one respawn. Pulse comer[1] again while fruit 1 is still pending: no second event.
- Assert comer = 4'b1010 in the same cycle: fruit 1 then fruit 3 respawn sequentially. busy stays high across both. With FRUIT_SPAWNER_SCORE_EN defined, eaten_count increases by 2.
- GRID_X = 2, GRID_Y = 1, NUM_FRUITS = 2, head at (0,0): the forced-accept path is exercised. Placement terminates within MAX_TRIES+3 cycles with cx < 2 and cy = 0.
- Assert rst during CHECK of a placement: all outputs return to reset values the next cycle, then a full respawn occurs.
